tile_input_frontend: RTL and testbench

Input front end for the tile-matching game: converts the raw DE1-SoC push-buttons and slide switches into clean, single-cycle game events. It delivers tile selections to the in-game FSM over a valid/ready handshake. It is the input-side counterpart of the display path: the game FSM and display consume state, and this block produces the user commands that drive it. It replaces the direct `~KEY[n]` wiring at the top level.

---
 rtl/tile_input_pkg.sv | 31 +++
 rtl/key_debounce.sv | 37 +++
 rtl/tile_input_frontend.sv | 121 ++++++++++++
 tb/tb_tile_input_frontend.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tile_input_pkg.sv
// Shared constants and one-hot helpers for the tile-matching game input front end.
package tile_input_pkg;

    localparam int unsigned NUM_KEYS   = 4;
    localparam int unsigned NUM_TILES  = 10;
    localparam int unsigned TILE_IDX_W = 4;

    localparam int unsigned KEY_QUIT  = 0;
    localparam int unsigned KEY_BEGIN = 1;
    localparam int unsigned KEY_SEL1  = 2;
    localparam int unsigned KEY_SEL2  = 3;

    localparam logic SLOT_FIRST  = 1'b0;
    localparam logic SLOT_SECOND = 1'b1;

    // True when exactly one switch is up.
    function automatic logic sw_onehot(input logic [NUM_TILES-1:0] sw);
        return (sw != '0) && ((sw & (sw - NUM_TILES'(1))) == '0);
    endfunction

    // Position of the set bit; only meaningful when sw_onehot(sw) holds.
    function automatic logic [TILE_IDX_W-1:0] onehot_index(input logic [NUM_TILES-1:0] sw);
        logic [TILE_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_TILES; i++) begin
            if (sw[i]) idx = TILE_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: accepts a level change after DEBOUNCE_CYCLES consecutive differing
// synced samples and emits a one-cycle press pulse on a stable 1->0 transition.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic stable,
    output logic press
);

    logic [CNT_W-1:0] cnt;
    logic             flip_c;

    assign flip_c = (sync_in != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b1;
            press  <= 1'b0;
        end else begin
            press <= flip_c & ~sync_in;
            if (sync_in == stable) begin
                cnt <= '0;
            end else if (flip_c) begin
                cnt    <= '0;
                stable <= sync_in;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tile_input_frontend.sv
// Input front end: synchronizes and debounces the DE1-SoC keys/switches and turns
// presses into game events plus a valid/ready tile-selection holding register.
module tile_input_frontend
    import tile_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic       quit_pulse,
    output logic       begin_pulse,
    output logic       sel_valid,
    output logic [3:0] sel_index,
    output logic       sel_slot,
    input  logic       sel_ready,
    output logic       sel_error,
    output logic       sel_drop
);

    logic [NUM_KEYS-1:0]   key_meta, key_sync;
    logic [NUM_TILES-1:0]  sw_meta, sw_sync, sw_snap;
    logic [NUM_KEYS-1:0]   key_stable, key_press, key_evt;

    logic                  quit_n, begin_n, error_n, drop_n, valid_n, slot_n;
    logic [TILE_IDX_W-1:0] index_n;
    logic                  sel_any;

    // sw_snap holds the synced switches as seen on the edge where a key's stable value flips.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_meta <= '1;
            key_sync <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
            sw_snap  <= '0;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            sw_snap  <= sw_sync;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (CLOCK_50),
            .reset  (reset),
            .sync_in(key_sync[k]),
            .stable (key_stable[k]),
            .press  (key_press[k])
        );
    end

    // A press is only honoured while the debounced level is actually low.
    assign key_evt = key_press & ~key_stable;

    always_comb begin
        quit_n  = key_evt[KEY_QUIT];
        begin_n = key_evt[KEY_BEGIN];
        error_n = 1'b0;
        drop_n  = 1'b0;
        valid_n = sel_valid;
        index_n = sel_index;
        slot_n  = sel_slot;
        sel_any = key_evt[KEY_SEL1] | key_evt[KEY_SEL2];

        if (sel_valid && sel_ready) valid_n = 1'b0;

        if (sel_any) begin
            if (!sw_onehot(sw_snap)) begin
                error_n = 1'b1;
            end else begin
                // KEY_SEL1 wins a tie; the simultaneous second pick is lost.
                if (key_evt[KEY_SEL1] && key_evt[KEY_SEL2]) drop_n = 1'b1;
                if (!sel_valid || sel_ready) begin
                    valid_n = 1'b1;
                    index_n = onehot_index(sw_snap);
                    slot_n  = key_evt[KEY_SEL1] ? SLOT_FIRST : SLOT_SECOND;
                end else begin
                    drop_n = 1'b1;
                end
            end
        end

        // Quit flushes the register and silently discards any same-cycle selection.
        if (quit_n) begin
            valid_n = 1'b0;
            index_n = sel_index;
            slot_n  = sel_slot;
            drop_n  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            quit_pulse  <= 1'b0;
            begin_pulse <= 1'b0;
            sel_error   <= 1'b0;
            sel_drop    <= 1'b0;
            sel_valid   <= 1'b0;
            sel_index   <= '0;
            sel_slot    <= 1'b0;
        end else begin
            quit_pulse  <= quit_n;
            begin_pulse <= begin_n;
            sel_error   <= error_n;
            sel_drop    <= drop_n;
            sel_valid   <= valid_n;
            sel_index   <= index_n;
            sel_slot    <= slot_n;
        end
    end

endmodule

// File: tb/tb_tile_input_frontend.sv
// Directed bench for tile_input_frontend with DEBOUNCE_CYCLES=4.
module tb_tile_input_frontend;

    logic       CLOCK_50;
    logic       reset;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic       quit_pulse, begin_pulse, sel_valid, sel_slot, sel_ready, sel_error, sel_drop;
    logic [3:0] sel_index;

    int checks   = 0;
    int failures = 0;
    int hits;

    tile_input_frontend #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .KEY        (KEY),
        .SW         (SW),
        .quit_pulse (quit_pulse),
        .begin_pulse(begin_pulse),
        .sel_valid  (sel_valid),
        .sel_index  (sel_index),
        .sel_slot   (sel_slot),
        .sel_ready  (sel_ready),
        .sel_error  (sel_error),
        .sel_drop   (sel_drop)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Steps n cycles, counting cycles on which a given event output is high.
    task automatic count_evt(input int n, input int which, output int cnt);
        cnt = 0;
        repeat (n) begin
            step(1);
            case (which)
                0: cnt += int'(quit_pulse);
                1: cnt += int'(begin_pulse);
                default: cnt += int'(sel_drop);
            endcase
        end
    endtask

    function automatic logic [7:0] outs();
        return {quit_pulse, begin_pulse, sel_valid, sel_slot, sel_error, sel_drop, |sel_index, 1'b0};
    endfunction

    initial begin
        reset = 1'b1; KEY = 4'hF; SW = '0; sel_ready = 1'b0;
        step(3);
        check("reset_outputs", 32'(outs()), 32'h0);
        reset = 1'b0;
        step(2);

        // Reset mid-count with KEY[1] held low
        KEY[1] = 1'b0;
        step(4);
        reset = 1'b1;
        #1;
        check("reset_mid_outputs", 32'(outs()), 32'h0);
        step(2);
        reset = 1'b0;
        count_evt(6, 1, hits);
        check("begin_none_early", 32'(hits), 32'd0);
        step(1);
        check("begin_at_edge7", 32'(begin_pulse), 32'd1);
        step(1);
        check("begin_one_cycle", 32'(begin_pulse), 32'd0);
        KEY[1] = 1'b1;
        step(8);

        // Bounce on KEY[0]: 3 low, 1 high, repeated
        hits = 0;
        for (int r = 0; r < 4; r++) begin
            int c;
            KEY[0] = 1'b0;
            count_evt(3, 0, c);
            hits += c;
            KEY[0] = 1'b1;
            count_evt(1, 0, c);
            hits += c;
        end
        check("bounce_no_quit", 32'(hits), 32'd0);
        KEY[0] = 1'b0;
        count_evt(6, 0, hits);
        check("quit_none_early", 32'(hits), 32'd0);
        step(1);
        check("quit_at_edge7", 32'(quit_pulse), 32'd1);
        count_evt(12, 0, hits);
        check("quit_hold_single", 32'(hits), 32'd0);
        KEY[0] = 1'b1;
        step(8);

        // Handshake: index 5, first slot, held while not ready
        SW = 10'b0000100000;
        step(3);
        KEY[2] = 1'b0;
        step(7);
        check("hs_valid", 32'(sel_valid), 32'd1);
        check("hs_index", 32'(sel_index), 32'd5);
        check("hs_slot", 32'(sel_slot), 32'd0);
        step(4);
        check("hs_hold", 32'({sel_valid, sel_index, sel_slot}), 32'({1'b1, 4'd5, 1'b0}));
        sel_ready = 1'b1;
        step(1);
        check("hs_accept", 32'(sel_valid), 32'd0);
        sel_ready = 1'b0;
        KEY[2] = 1'b1;
        step(8);

        // Invalid switch patterns on KEY[3]
        for (int t = 0; t < 2; t++) begin
            SW = (t == 0) ? 10'b0000000011 : 10'b0;
            step(3);
            KEY[3] = 1'b0;
            step(7);
            check("inv_error", 32'(sel_error), 32'd1);
            check("inv_no_valid", 32'(sel_valid), 32'd0);
            step(1);
            check("inv_error_clear", 32'(sel_error), 32'd0);
            KEY[3] = 1'b1;
            step(8);
        end

        // Overrun: pending index 2, second press while not ready
        SW = 10'b0000000100;
        step(3);
        KEY[2] = 1'b0;
        step(7);
        check("ovr_first_index", 32'(sel_index), 32'd2);
        KEY[2] = 1'b1;
        step(8);
        SW = 10'b1000000000;
        step(3);
        KEY[3] = 1'b0;
        step(7);
        check("ovr_drop", 32'(sel_drop), 32'd1);
        check("ovr_kept", 32'({sel_valid, sel_index, sel_slot}), 32'({1'b1, 4'd2, 1'b0}));
        step(1);
        check("ovr_drop_clear", 32'(sel_drop), 32'd0);
        KEY[3] = 1'b1;
        step(8);

        // Reload: ready on the press cycle
        KEY[3] = 1'b0;
        step(6);
        sel_ready = 1'b1;
        step(1);
        check("reload_entry", 32'({sel_valid, sel_index, sel_slot}), 32'({1'b1, 4'd9, 1'b1}));
        check("reload_no_drop", 32'(sel_drop), 32'd0);
        sel_ready = 1'b0;
        KEY[3] = 1'b1;
        step(8);
        check("reload_still_pending", 32'(sel_valid), 32'd1);

        // Quit flushes pending selection
        KEY[0] = 1'b0;
        step(7);
        check("flush_quit", 32'(quit_pulse), 32'd1);
        check("flush_valid", 32'(sel_valid), 32'd0);
        KEY[0] = 1'b1;
        step(8);

        // Simultaneous select presses
        SW = 10'b0000001000;
        step(3);
        KEY[3:2] = 2'b00;
        step(7);
        check("simul_entry", 32'({sel_valid, sel_index, sel_slot}), 32'({1'b1, 4'd3, 1'b0}));
        check("simul_drop", 32'(sel_drop), 32'd1);
        KEY[3:2] = 2'b11;
        step(8);

        // Asynchronous reset clears a pending selection immediately
        reset = 1'b1;
        #1;
        check("reset_flush", 32'({sel_valid, sel_index}), 32'd0);
        step(1);
        reset = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
